// File: rtl/add32_byte_serial_pkg.sv
// Shared constants and types for the byte-serial 32-bit adder.
//   WIDTH  : operand/result width
//   SLICE  : bits added per clock
//   NSLICE : number of slice cycles per operation
//   state_e: controller states
package add32_byte_serial_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SLICE  = 8;
    localparam int unsigned NSLICE = WIDTH / SLICE;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

endpackage

// File: rtl/add32_byte_serial_add8_slice.sv
// Purely combinational 8-bit adder with carry in/out, used for one byte slice.
//   a_i, b_i : 8-bit addends
//   cin_i    : carry in
//   sum_o    : 8-bit sum
//   cout_o   : carry out of bit 7
module add8_slice
    import add32_byte_serial_pkg::*;
(
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o
);

    logic [SLICE:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};
    assign sum_o    = full_sum[SLICE-1:0];
    assign cout_o   = full_sum[SLICE];

endmodule

// File: rtl/add32_byte_serial.sv
// Multi-cycle 32-bit unsigned adder, one byte per clock, LSB first.
// A capture edge (idle + adv_i) latches the operands; the next four edges each
// add one byte slice, writing it into result_o and the slice carry into c8_o.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   adv_i    : start request, honoured only while idle
//   in_a_i   : operand A, sampled on the capture edge
//   in_b_i   : operand B, sampled on the capture edge
//   result_o : registered sum (final after the fourth slice edge)
//   c8_o     : registered carry out of the most recent slice (bit 32 when final)
module add32_byte_serial
    import add32_byte_serial_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             c8_o
);

    localparam logic [1:0] LastSlice = 2'(NSLICE - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cin_q;
    logic             c8_q;
    logic [1:0]       k_q;

    logic [SLICE-1:0] a_slice, b_slice, sum_slice;
    logic             cout_slice;

    // Select the operand bytes for the current slice index.
    always_comb begin
        a_slice = a_q[7:0];
        b_slice = b_q[7:0];
        case (k_q)
            2'd0: begin a_slice = a_q[7:0];   b_slice = b_q[7:0];   end
            2'd1: begin a_slice = a_q[15:8];  b_slice = b_q[15:8];  end
            2'd2: begin a_slice = a_q[23:16]; b_slice = b_q[23:16]; end
            default: begin a_slice = a_q[31:24]; b_slice = b_q[31:24]; end
        endcase
    end

    add8_slice u_add8_slice (
        .a_i    (a_slice),
        .b_i    (b_slice),
        .cin_i  (cin_q),
        .sum_o  (sum_slice),
        .cout_o (cout_slice)
    );

    // Merge the new slice into the result; other bytes hold.
    always_comb begin
        result_d = result_q;
        case (k_q)
            2'd0:    result_d[7:0]   = sum_slice;
            2'd1:    result_d[15:8]  = sum_slice;
            2'd2:    result_d[23:16] = sum_slice;
            default: result_d[31:24] = sum_slice;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cin_q    <= 1'b0;
            c8_q     <= 1'b0;
            k_q      <= 2'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (adv_i) begin
                        a_q      <= in_a_i;
                        b_q      <= in_b_i;
                        result_q <= '0;
                        cin_q    <= 1'b0;
                        c8_q     <= 1'b0;
                        k_q      <= 2'd0;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    // adv_i is deliberately ignored here.
                    result_q <= result_d;
                    c8_q     <= cout_slice;
                    cin_q    <= cout_slice;
                    k_q      <= k_q + 2'd1;
                    if (k_q == LastSlice) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result_o = result_q;
    assign c8_o     = c8_q;

endmodule

// File: tb/tb_add32_byte_serial.sv
module tb_add32_byte_serial;

    logic        clk;
    logic        rst_n;
    logic        adv;
    logic [31:0] in_a, in_b;
    logic [31:0] result;
    logic        c8;

    int n_cmp = 0;
    int n_err = 0;

    add32_byte_serial dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .adv_i    (adv),
        .in_a_i   (in_a),
        .in_b_i   (in_b),
        .result_o (result),
        .c8_o     (c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_c;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Drive operands with adv high for one capture edge, then wait the four slice
    // edges and sample at the following negedge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_a = a;
        in_b = b;
        adv  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        adv = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // Capture then stop right after the first slice edge (sampled at negedge).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_a = a;
        in_b = b;
        adv  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        adv = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'h0000000A, 32'h0000000A, 32'h00000014, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[2] = '{32'h000000FF, 32'h00000001, 32'h00000100, 1'b0};
        vecs[3] = '{32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
        vecs[6] = '{32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0};
        vecs[7] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};

        // Reset with adv asserted: outputs must stay zero, no capture.
        rst_n = 1'b1;
        adv   = 1'b1;
        in_a  = 32'h0000000A;
        in_b  = 32'h0000000A;
        #1 rst_n = 1'b0;
        #1;
        check("reset_result", result, 32'h0);
        check("reset_c8", {31'b0, c8}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold_result", result, 32'h0);
        check("reset_hold_c8", {31'b0, c8}, 32'h0);
        adv   = 1'b0;
        rst_n = 1'b1;

        // Table-driven sums.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_r);
            check($sformatf("vec%0d_c8", i), {31'b0, c8}, {31'b0, vecs[i].exp_c});
        end

        // Full ripple: c8 set after every slice edge.
        start_op(32'hFFFFFFFF, 32'h00000001);
        for (int s = 0; s < 4; s++) begin
            if (s != 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            check($sformatf("ripple_s%0d_c8", s), {31'b0, c8}, 32'h1);
            check($sformatf("ripple_s%0d_result", s), result, 32'h0);
        end

        // Inter-byte carry.
        start_op(32'h000000FF, 32'h00000001);
        check("interbyte_s0_result", result, 32'h0);
        check("interbyte_s0_c8", {31'b0, c8}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("interbyte_s1_result", result, 32'h00000100);
        check("interbyte_s1_c8", {31'b0, c8}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("interbyte_final_result", result, 32'h00000100);
        check("interbyte_final_c8", {31'b0, c8}, 32'h0);

        // Operand changes and adv pulse while busy are ignored.
        start_op(32'h12345678, 32'h11111111);
        in_a = 32'hFFFFFFFF;
        in_b = 32'hFFFFFFFF;
        adv  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        adv = 1'b0;
        check("busy_s1_result", result, 32'h00006789);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_final_result", result, 32'h23456789);
        check("busy_final_c8", {31'b0, c8}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("busy_idle_hold", result, 32'h23456789);

        // Asynchronous reset mid-operation.
        start_op(32'h01010101, 32'h01010101);
        @(posedge clk);
        @(negedge clk);
        check("midrst_partial", result, 32'h00000202);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_result", result, 32'h0);
        check("midrst_c8", {31'b0, c8}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("midrst_no_capture", result, 32'h0);
        run_op(32'h80000000, 32'h80000000);
        check("midrst_new_result", result, 32'h0);
        check("midrst_new_c8", {31'b0, c8}, 32'h1);

        // adv held high: a capture every 5 edges with the operands present then.
        @(negedge clk);
        adv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = vecs[i + 5].a;
            in_b = vecs[i + 5].b;
            @(posedge clk);
            @(negedge clk);
            in_a = 32'hDEADBEEF;
            in_b = 32'h0BADF00D;
            repeat (4) @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b%0d_result", i), result, vecs[i + 5].exp_r);
            check($sformatf("b2b%0d_c8", i), {31'b0, c8}, {31'b0, vecs[i + 5].exp_c});
        end
        adv = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/add32_byte_serial.md
Name: add32_byte_serial

Overview:
- Multi-cycle 32-bit unsigned adder that processes one 8-bit slice per clock, least significant byte first.
- Operation starts on `adv`. After four slice cycles, `result` holds the 32-bit sum and `c8` holds the carry out of bit 31.
- Used wherever a small-area, low-fanout adder is preferred over a single-cycle 32-bit carry chain.

Parameters:
- WIDTH, 32, operand/result width; fixed, not overridable in this revision.
- SLICE, 8, bits added per cycle; WIDTH/SLICE = 4 slice cycles.

Ports:
- clk     input   1   single clock; all state updates on rising edge
- rst     input   1   asynchronous, active-low reset
- adv     input   1   start/advance request; sampled on rising clk edge while idle
- in_a    input   32  operand A; sampled only on the capture edge
- in_b    input   32  operand B; sampled only on the capture edge
- result  output  32  registered sum; partially updated during operation, final after last slice
- c8      output  1   registered carry out of the most recently added 8-bit slice; after the final slice, carry out of bit 31

Behaviour:
- Clocking and reset:
  - One clock `clk`. Reset `rst` is asynchronous and active-low.
  - While rst=0: state=IDLE, result=0, c8=0, internal operand/carry/slice-index registers=0. Takes effect immediately, independent of clk.
- States: IDLE, BUSY. Slice index k (0..3) is held in a 2-bit counter.
- Capture (edge N):
  - Condition: IDLE and adv=1 at a rising edge.
  - Latch in_a, in_b into internal registers.
  - Clear carry-in to 0, set k=0, set result=0 and c8=0, go to BUSY.
- Slice cycles (edges N+1 .. N+4), each edge in BUSY:
  - Compute {cout, sum8} = A[8k+7:8k] + B[8k+7:8k] + cin.
  - Write result[8k+7:8k] = sum8; c8 = cout; cin for the next slice = cout.
  - Bytes of result other than slice k hold their value.
- Completion:
  - On the edge where k=3 is processed (N+4), return to IDLE.
  - result and c8 are final and valid from after edge N+4 until the next capture or reset.
- Latency: 4 clock cycles from the capture edge to the final result. Back-to-back operations are possible: adv=1 on edge N+5 starts the next operation.
- adv while BUSY: ignored; no restart, no effect.
- adv held high continuously: a new capture occurs at every edge where the block is IDLE.
- in_a/in_b changes after capture have no effect on the running operation.
- Arithmetic is unsigned modulo 2^32. The final c8 equals bit 32 of in_a+in_b as captured.
- Reset mid-operation: operation aborted, all outputs 0, IDLE. A capture requires a fresh adv after rst returns high.
- No combinational path from inputs to outputs.

Decomposition:
- Package add32_byte_serial_pkg:
  - constants WIDTH=32, SLICE=8, NSLICE=4
  - state typedef enum {IDLE, BUSY}
- Sub-module add8_slice: purely combinational 8-bit adder (a[7:0], b[7:0], cin) -> (sum[7:0], cout).
- The top level holds the FSM, the operand/carry/result registers and the slice mux.

Test Plan:
- Reset and basic sum:
  - Stimulus: rst=0 then 1; in_a=0x0000000A, in_b=0x0000000A, adv pulse 1 cycle.
  - Required: result=0 and c8=0 during reset; after 4 further edges, result=0x00000014, c8=0.
- Full carry ripple:
  - Stimulus: in_a=0xFFFFFFFF, in_b=0x00000001.
  - Required: final result=0x00000000, c8=1; c8=1 after each slice edge.
- Inter-byte carry:
  - Stimulus: in_a=0x000000FF, in_b=0x00000001.
  - Required: after first slice, result=0x00000000 and c8=1; final result=0x00000100, c8=0.
- Operand stability and busy-adv:
  - Stimulus: capture 0x12345678 + 0x11111111; change in_a/in_b and pulse adv during BUSY.
  - Required: final result=0x23456789, c8=0; no restart.
- Reset mid-operation:
  - Stimulus: assert rst=0 asynchronously (between edges) at slice 2.
  - Required: result=0 and c8=0 immediately, IDLE; a new capture of 0x80000000+0x80000000 gives result=0, c8=1.
- Back-to-back:
  - Stimulus: adv held high.
  - Required: captures every 5 edges; each result correct for the operands present at its capture edge.
